// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX core
// among NREQ byte requesters, with busy sync and guard gap.
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int START_CYC = 6,
    parameter int GAP_CYC   = 4,
    parameter int BUSY_TO   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [DW-1:0]      txpd,
    output logic               tstart,
    input  logic               tx_busy,
    output logic               arb_busy,
    output logic [2:0]         cur_id,
    output logic               to_err
);
    localparam int PW = $clog2(NREQ);
    localparam int M1 = (START_CYC > GAP_CYC) ? START_CYC : GAP_CYC;
    localparam int MX = (BUSY_TO > M1) ? BUSY_TO : M1;
    localparam int CW = $clog2(MX + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_RISE,
        WAIT_FALL,
        GAP
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] idx;
    logic [DW-1:0] sel_data;
    logic          found;
    logic          sync1;
    logic          bsy_s;
    logic          do_gnt;
    logic          do_to;

    assign tstart   = (state == START);
    assign arb_busy = (state != IDLE);

    // bring tx_busy from the txck domain into clk
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            bsy_s <= 1'b0;
        end else begin
            sync1 <= tx_busy;
            bsy_s <= sync1;
        end
    end

    // first pending requester at or after ptr, wrapping
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // byte of the current winner
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) sel_data = req_data[i*DW +: DW];
        end
    end

    // frame sequencing: grant, strobe, busy rise/fall, guard gap
    always_comb begin
        state_n = state;
        do_gnt  = 1'b0;
        do_to   = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = START;
                    do_gnt  = 1'b1;
                end
            end
            START: begin
                if (cnt == CW'(START_CYC - 1)) state_n = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (bsy_s) begin
                    state_n = WAIT_FALL;
                end else if (cnt == CW'(BUSY_TO - 1)) begin
                    state_n = GAP;
                    do_to   = 1'b1;
                end
            end
            WAIT_FALL: begin
                if (!bsy_s) state_n = GAP;
            end
            GAP: begin
                if (cnt == CW'(GAP_CYC - 1)) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // per-state cycle counter, restarts on every state change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state_n != state) begin
            cnt <= '0;
        end else if (cnt != {CW{1'b1}}) begin
            cnt <= cnt + 1'b1;
        end
    end

    // grant capture, rotating pointer and timeout pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt    <= '0;
            txpd   <= '0;
            cur_id <= '0;
            ptr    <= '0;
            to_err <= 1'b0;
        end else begin
            gnt    <= '0;
            to_err <= do_to;
            if (do_gnt) begin
                gnt    <= NREQ'(1) << win;
                txpd   <= sel_data;
                cur_id <= 3'(win);
                ptr    <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: timeline model of the arbiter plus
// directed scenarios with literal expectations.
module tb_uart_tx_arbiter;
    localparam int NEVER = 1 << 30;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = 4'h0;
    logic [31:0] req_data = 32'h0;
    logic        tx_busy = 1'b0;
    logic [3:0]  gnt;
    logic [7:0]  txpd;
    logic        tstart;
    logic        arb_busy;
    logic [2:0]  cur_id;
    logic        to_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ(4), .DW(8), .START_CYC(6), .GAP_CYC(4), .BUSY_TO(64)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data),
        .gnt(gnt), .txpd(txpd), .tstart(tstart), .tx_busy(tx_busy),
        .arb_busy(arb_busy), .cur_id(cur_id), .to_err(to_err)
    );

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", nm, a, e);
        end
    endtask

    // TX core stand-in: busy from 3 cycles after tstart, 200 cycles
    bit tx_mode = 1'b1;
    int tx_cnt = 0;
    bit ts_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            tx_cnt  = 0;
            tx_busy = 1'b0;
            ts_prev = 1'b0;
        end else begin
            if (tx_cnt > 0) tx_cnt++;
            else if (tstart && !ts_prev && tx_mode) tx_cnt = 1;
            ts_prev = tstart;
            tx_busy = (tx_cnt > 3) && (tx_cnt <= 203);
            if (tx_cnt >= 204) tx_cnt = 0;
        end
    end

    function automatic int rr_pick(input int p, input logic [3:0] r);
        for (int i = 0; i < 4; i++) begin
            if (r[2'((p + i) % 4)]) return (p + i) % 4;
        end
        return -1;
    endfunction

    // model state: grant edge, busy-rise edge, edge the arbiter is free
    int         cyc = 0;
    int         mptr = 0;
    int         g_e = 0;
    int         rise_e = -1;
    int         free_e = -10;
    int         m_id = 0;
    int         w = 0;
    bit         act = 1'b0;
    bit         tmo = 1'b0;
    bit         b_now = 1'b0;
    bit         last_tx = 1'b0;
    logic [7:0] m_txpd = 8'h0;
    logic [3:0] eg;
    int         gq[$];
    logic [7:0] dq[$];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst) begin
            chk("rst_gnt", 32'(gnt), 32'h0);
            chk("rst_tstart", 32'(tstart), 32'h0);
            chk("rst_txpd", 32'(txpd), 32'h0);
            chk("rst_arb_busy", 32'(arb_busy), 32'h0);
            chk("rst_cur_id", 32'(cur_id), 32'h0);
            chk("rst_to_err", 32'(to_err), 32'h0);
            mptr = 0; act = 0; tmo = 0; rise_e = -1; free_e = -10;
            m_id = 0; m_txpd = 8'h0; b_now = 0; last_tx = 0;
        end else begin
            b_now   = last_tx;
            last_tx = tx_busy;
            if (act && cyc >= free_e) act = 0;
            eg = 4'h0;
            if (!act && cyc > free_e && req != 4'h0) begin
                w      = rr_pick(mptr, req);
                eg     = 4'(1 << w);
                act    = 1; g_e = cyc; rise_e = -1; tmo = 0;
                free_e = NEVER;
                m_txpd = 8'(req_data >> (w * 8));
                m_id   = w;
                mptr   = (w + 1) % 4;
                gq.push_back(w);
                dq.push_back(m_txpd);
            end
            chk("gnt", 32'(gnt), 32'(eg));
            chk("tstart", 32'(tstart), 32'(act && cyc <= g_e + 5));
            chk("arb_busy", 32'(arb_busy), 32'(act));
            chk("to_err", 32'(to_err), 32'(tmo && cyc == g_e + 70));
            chk("txpd", 32'(txpd), 32'(m_txpd));
            chk("cur_id", 32'(cur_id), 32'(m_id));
            if (act) begin
                if (rise_e < 0 && !tmo) begin
                    if (cyc >= g_e + 6 && b_now) begin
                        rise_e = cyc + 1;
                    end else if (cyc == g_e + 69) begin
                        tmo    = 1;
                        free_e = g_e + 74;
                    end
                end else if (rise_e >= 0 && free_e == NEVER &&
                             cyc >= rise_e && !b_now) begin
                    free_e = cyc + 5;
                end
            end
        end
    end

    task automatic wait_gnt(input int maxc, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(posedge clk); #1;
            if (gnt != 4'h0) ok = 1'b1;
        end
        chk(nm, 32'(ok), 32'h1);
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(posedge clk); #1;
            if (!arb_busy) ok = 1'b1;
        end
        chk(nm, 32'(ok), 32'h1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    int         eid[5] = '{0, 1, 2, 3, 0};
    logic [7:0] ed[5]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    int         n;

    initial begin
        req      = 4'hF;
        req_data = 32'h44332211;
        rst      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("t1_rst_gnt", 32'(gnt), 32'h0);
        chk("t1_rst_tstart", 32'(tstart), 32'h0);
        chk("t1_rst_txpd", 32'(txpd), 32'h0);
        chk("t1_rst_busy", 32'(arb_busy), 32'h0);
        @(negedge clk) rst = 1'b1;
        wait_gnt(10, "t1_wait");
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_txpd", 32'(txpd), 32'h11);

        repeat (4) wait_gnt(400, "t3_wait");
        @(negedge clk) req = 4'h0;
        chk("t3_count", 32'(gq.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("t3_order", 32'((i < gq.size()) ? gq[i] : -1), 32'(eid[i]));
            chk("t3_data", 32'((i < dq.size()) ? dq[i] : 8'h0), 32'(ed[i]));
        end
        wait_idle(400, "t3_idle");

        @(negedge clk);
        req = 4'b0100;
        req_data[23:16] = 8'h3A;
        wait_gnt(10, "t2_wait");
        chk("t2_gnt", 32'(gnt), 32'h4);
        chk("t2_txpd", 32'(txpd), 32'h3A);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!tstart) break;
            n++;
        end
        chk("t2_tstart_len", 32'(n), 32'd6);
        @(negedge clk) req = 4'h0;
        wait_idle(400, "t2_idle");

        @(negedge clk);
        tx_mode = 1'b0;
        req = 4'b0001;
        wait_gnt(10, "t4_wait");
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            n++;
            if (to_err) break;
        end
        chk("t4_to_delay", 32'(n), 32'd70);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            n++;
            if (gnt != 4'h0) break;
        end
        chk("t4_regrant_delay", 32'(n), 32'd5);
        chk("t4_regrant", 32'(gnt), 32'h1);
        @(negedge clk) req = 4'h0;
        wait_idle(200, "t4_idle");
        tx_mode = 1'b1;

        @(negedge clk) req = 4'b0010;
        wait_gnt(10, "t5_wait");
        chk("t5_gnt", 32'(gnt), 32'h2);
        @(negedge clk) req = 4'h0;
        repeat (30) @(negedge clk);
        #1 chk("t5_in_frame", 32'(arb_busy), 32'h1);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("t5_rst_tstart", 32'(tstart), 32'h0);
        chk("t5_rst_busy", 32'(arb_busy), 32'h0);
        chk("t5_rst_gnt", 32'(gnt), 32'h0);
        req = 4'b1001;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_gnt(10, "t5_wait2");
        chk("t5_gnt0", 32'(gnt), 32'h1);
        chk("t5_txpd0", 32'(txpd), 32'h11);
        @(negedge clk) req = 4'b1000;
        wait_gnt(400, "t5_wait3");
        chk("t5_gnt3", 32'(gnt), 32'h8);
        chk("t5_txpd3", 32'(txpd), 32'h44);
        @(negedge clk) req = 4'h0;
        wait_idle(400, "t5_idle");

        @(negedge clk);
        req_data[7:0] = 8'h5A;
        req = 4'b0001;
        wait_gnt(10, "t6_wait");
        chk("t6_txpd0", 32'(txpd), 32'h5A);
        @(negedge clk) req = 4'h0;
        repeat (30) @(negedge clk);
        req_data[15:8] = 8'hFF;
        req = 4'b0010;
        repeat (100) @(negedge clk);
        #1;
        chk("t6_hold_txpd", 32'(txpd), 32'h5A);
        chk("t6_still_busy", 32'(arb_busy), 32'h1);
        wait_gnt(200, "t6_wait2");
        chk("t6_gnt1", 32'(gnt), 32'h2);
        chk("t6_txpd1", 32'(txpd), 32'hFF);
        @(negedge clk) req = 4'h0;
        wait_idle(400, "t6_idle");

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
